// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit - program-counter unit for the piRISC core.
//
// Holds the architectural PC and selects the next PC for sequential, branch,
// JAL, JALR, trap and MRET flows. Control-flow targets that break instruction
// alignment are redirected to the trap vector, with the faulting PC saved in
// EPC. A retire counter counts every non-trap PC update.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   stall         in   hold PC, EPC and retire counter this cycle
//   pc_select     in   next-PC mode (SEQ/BRANCH/JAL/JALR/MRET, 101-111 = SEQ)
//   branch_taken  in   branch comparison result, BRANCH mode only
//   immgen_in     in   sign-extended immediate
//   alu_in        in   ALU result (rs1+imm for JALR)
//   trap_req      in   trap request; wins over stall and misalignment
//   trap_vector   in   trap handler base, low two bits ignored
//   pc_value      out  current PC (registered)
//   link_addr     out  pc_value+4, combinational return address
//   epc           out  PC saved on the last trap (registered)
//   misaligned    out  one-cycle pulse when a misaligned target was trapped
//   retire_count  out  count of non-trap PC updates, wraps (registered)
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
  parameter int                IALIGN       = 32,
  parameter int                CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [2:0]           pc_select,
  input  logic                 branch_taken,
  input  logic [DWIDTH-1:0]    immgen_in,
  input  logic [DWIDTH-1:0]    alu_in,
  input  logic                 trap_req,
  input  logic [DWIDTH-1:0]    trap_vector,
  output logic [DWIDTH-1:0]    pc_value,
  output logic [DWIDTH-1:0]    link_addr,
  output logic [DWIDTH-1:0]    epc,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] retire_count
);

  // Next-PC mode encoding; 101-111 fall through to SEQ.
  localparam logic [2:0] SEL_SEQ    = 3'b000;
  localparam logic [2:0] SEL_BRANCH = 3'b001;
  localparam logic [2:0] SEL_JAL    = 3'b010;
  localparam logic [2:0] SEL_JALR   = 3'b011;
  localparam logic [2:0] SEL_MRET   = 3'b100;

  localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

  logic [DWIDTH-1:0]    r_pc;
  logic [DWIDTH-1:0]    r_epc;
  logic                 r_misaligned;
  logic [CNT_WIDTH-1:0] r_retire_count;

  logic [DWIDTH-1:0]    w_pc_plus4;
  logic [DWIDTH-1:0]    w_pc_plus_imm;
  logic [DWIDTH-1:0]    w_target;
  logic [DWIDTH-1:0]    w_trap_target;
  logic                 w_target_misaligned;

  // All sums wrap modulo 2^DWIDTH; a negative immediate simply subtracts.
  assign w_pc_plus4    = r_pc + PC_STEP;
  assign w_pc_plus_imm = r_pc + immgen_in;

  // The handler entry is always word aligned regardless of IALIGN.
  assign w_trap_target = trap_vector & ~DWIDTH'(3);

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_target = w_pc_plus4;
    unique case (pc_select)
      SEL_SEQ:    w_target = w_pc_plus4;
      SEL_BRANCH: w_target = branch_taken ? w_pc_plus_imm : w_pc_plus4;
      SEL_JAL:    w_target = w_pc_plus_imm;
      // JALR clears bit 0 before the alignment check sees the address.
      SEL_JALR:   w_target = alu_in & ~DWIDTH'(1);
      SEL_MRET:   w_target = r_epc;
      default:    w_target = w_pc_plus4;
    endcase
  end

  // Alignment rule depends on whether compressed instructions exist.
  generate
    if (IALIGN == 16) begin : g_align16
      assign w_target_misaligned = w_target[0];
    end else begin : g_align32
      assign w_target_misaligned = |w_target[1:0];
    end
  endgenerate

  // Priority: rst > trap_req > stall > misaligned target > normal update.
  // Checking stall ahead of misalignment is equivalent to the architectural
  // ordering because a misaligned target is never evaluated while stalled.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values (epc captures the old PC, not the new one).
  // NOTE: reset is synchronous and covers every register explicitly; there is
  // no storage array here that would be left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_VECTOR;
      r_epc          <= '0;
      r_misaligned   <= 1'b0;
      r_retire_count <= '0;
    end else if (trap_req) begin
      r_pc           <= w_trap_target;
      r_epc          <= r_pc;
      r_misaligned   <= 1'b0;
      r_retire_count <= r_retire_count;
    end else if (stall) begin
      r_pc           <= r_pc;
      r_epc          <= r_epc;
      r_misaligned   <= 1'b0;
      r_retire_count <= r_retire_count;
    end else if (w_target_misaligned) begin
      // epc records the PC of the faulting control-flow instruction.
      r_pc           <= w_trap_target;
      r_epc          <= r_pc;
      r_misaligned   <= 1'b1;
      r_retire_count <= r_retire_count;
    end else begin
      r_pc           <= w_target;
      r_epc          <= r_epc;
      r_misaligned   <= 1'b0;
      r_retire_count <= r_retire_count + CNT_WIDTH'(1);
    end
  end

  assign pc_value     = r_pc;
  assign link_addr    = w_pc_plus4;
  assign epc          = r_epc;
  assign misaligned   = r_misaligned;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit - self-checking bench for pc_unit.
// Three instances share one stimulus stream:
//   k=0 : RESET_VECTOR=0x100, IALIGN=32, CNT_WIDTH=32
//   k=1 : RESET_VECTOR=0x100, IALIGN=16, CNT_WIDTH=32
//   k=2 : RESET_VECTOR=0x100, IALIGN=32, CNT_WIDTH=4
// A behavioural model advances once per clock edge from the architectural
// rules; directed scenarios compare against constants, the random phase
// compares every output of every instance against the model.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_select;
  logic        branch_taken;
  logic [31:0] immgen_in;
  logic [31:0] alu_in;
  logic        trap_req;
  logic [31:0] trap_vector;

  logic [31:0] pc_o   [3];
  logic [31:0] link_o [3];
  logic [31:0] epc_o  [3];
  logic        mis_o  [3];
  logic [31:0] cnt_o  [3];
  logic [31:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  assign cnt_o[0] = cnt_a;
  assign cnt_o[1] = cnt_b;
  assign cnt_o[2] = {28'b0, cnt_c};

  // Behavioural model state.
  logic [31:0] m_pc  [3];
  logic [31:0] m_epc [3];
  logic        m_mis [3];
  logic [31:0] m_cnt [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit #(.DWIDTH(32), .RESET_VECTOR(RV), .IALIGN(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_select(pc_select),
    .branch_taken(branch_taken), .immgen_in(immgen_in), .alu_in(alu_in),
    .trap_req(trap_req), .trap_vector(trap_vector),
    .pc_value(pc_o[0]), .link_addr(link_o[0]), .epc(epc_o[0]),
    .misaligned(mis_o[0]), .retire_count(cnt_a));

  pc_unit #(.DWIDTH(32), .RESET_VECTOR(RV), .IALIGN(16), .CNT_WIDTH(32)) dut16 (
    .clk(clk), .rst(rst), .stall(stall), .pc_select(pc_select),
    .branch_taken(branch_taken), .immgen_in(immgen_in), .alu_in(alu_in),
    .trap_req(trap_req), .trap_vector(trap_vector),
    .pc_value(pc_o[1]), .link_addr(link_o[1]), .epc(epc_o[1]),
    .misaligned(mis_o[1]), .retire_count(cnt_b));

  pc_unit #(.DWIDTH(32), .RESET_VECTOR(RV), .IALIGN(32), .CNT_WIDTH(4)) dut_c4 (
    .clk(clk), .rst(rst), .stall(stall), .pc_select(pc_select),
    .branch_taken(branch_taken), .immgen_in(immgen_in), .alu_in(alu_in),
    .trap_req(trap_req), .trap_vector(trap_vector),
    .pc_value(pc_o[2]), .link_addr(link_o[2]), .epc(epc_o[2]),
    .misaligned(mis_o[2]), .retire_count(cnt_c));

  // One architectural step per instance, straight from the rules.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int unsigned align_bytes = (k == 1) ? 2 : 4;
      int unsigned cnt_mod     = (k == 2) ? 16 : 0;
      logic [31:0] tgt;
      if (rst) begin
        m_pc[k] = RV; m_epc[k] = 0; m_mis[k] = 0; m_cnt[k] = 0;
      end else if (trap_req) begin
        m_epc[k] = m_pc[k];
        m_pc[k]  = (trap_vector / 4) * 4;
        m_mis[k] = 0;
      end else if (stall) begin
        m_mis[k] = 0;
      end else begin
        case (pc_select)
          3'd1:    tgt = branch_taken ? m_pc[k] + immgen_in : m_pc[k] + 4;
          3'd2:    tgt = m_pc[k] + immgen_in;
          3'd3:    tgt = (alu_in / 2) * 2;
          3'd4:    tgt = m_epc[k];
          default: tgt = m_pc[k] + 4;
        endcase
        if (tgt % align_bytes != 0) begin
          m_epc[k] = m_pc[k];
          m_pc[k]  = (trap_vector / 4) * 4;
          m_mis[k] = 1;
        end else begin
          m_pc[k]  = tgt;
          m_cnt[k] = (cnt_mod == 0) ? m_cnt[k] + 1 : (m_cnt[k] + 1) % cnt_mod;
          m_mis[k] = 0;
        end
      end
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; pc_select = 3'b000; branch_taken = 0;
    immgen_in = 0; alu_in = 0; trap_req = 0; trap_vector = 32'h800;
  endtask

  // Use a trap to land every instance on a known PC.
  task automatic goto_pc(input logic [31:0] addr);
    idle_inputs();
    trap_req = 1; trap_vector = addr;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (pc_o[k] !== RV || epc_o[k] !== 32'h0 || mis_o[k] !== 1'b0 ||
          cnt_o[k] !== 32'h0 || link_o[k] !== 32'h104) begin
        bad++;
        $display("FAIL reset[%0d]: got pc=%h epc=%h mis=%b cnt=%0d link=%h exp pc=%h epc=0 mis=0 cnt=0 link=104",
                 k, pc_o[k], epc_o[k], mis_o[k], cnt_o[k], link_o[k], RV);
      end
    end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3] = '{32'h104, 32'h108, 32'h10C};
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pc_o[0] !== exp_pc[i]) begin
        bad++;
        $display("FAIL seq_pc%0d: got %h exp %h", i, pc_o[0], exp_pc[i]);
      end
    end
    total++;
    if (cnt_o[0] !== 32'd3 || link_o[0] !== 32'h110) begin
      bad++;
      $display("FAIL seq_cnt_link: got cnt=%0d link=%h exp cnt=3 link=110", cnt_o[0], link_o[0]);
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h200);
    pc_select = 3'b001; immgen_in = 32'hFFFF_FFF0; branch_taken = 0;
    tick();
    total++;
    if (pc_o[0] !== 32'h204) begin
      bad++;
      $display("FAIL branch_not_taken: got %h exp 00000204", pc_o[0]);
    end
    goto_pc(32'h200);
    pc_select = 3'b001; immgen_in = 32'hFFFF_FFF0; branch_taken = 1;
    tick();
    total++;
    if (pc_o[0] !== 32'h1F0) begin
      bad++;
      $display("FAIL branch_taken: got %h exp 000001f0", pc_o[0]);
    end
  endtask

  task automatic test_jalr_misaligned();
    logic [31:0] old_pc, old_cnt;
    goto_pc(32'h500);
    old_pc  = m_pc[0];
    old_cnt = m_cnt[0];
    pc_select = 3'b011; alu_in = 32'h0000_1003; trap_vector = 32'h800;
    tick();
    total++;
    if (pc_o[0] !== 32'h800 || epc_o[0] !== old_pc || mis_o[0] !== 1'b1 || cnt_o[0] !== old_cnt) begin
      bad++;
      $display("FAIL jalr_mis32: got pc=%h epc=%h mis=%b cnt=%0d exp pc=800 epc=%h mis=1 cnt=%0d",
               pc_o[0], epc_o[0], mis_o[0], cnt_o[0], old_pc, old_cnt);
    end
    total++;
    if (pc_o[1] !== 32'h1002 || mis_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL jalr_ok16: got pc=%h mis=%b exp pc=00001002 mis=0", pc_o[1], mis_o[1]);
    end
    idle_inputs();
    tick();
    total++;
    if (mis_o[0] !== 1'b0 || pc_o[0] !== 32'h804 || cnt_o[0] !== old_cnt + 1) begin
      bad++;
      $display("FAIL mis_pulse_end: got mis=%b pc=%h cnt=%0d exp mis=0 pc=804 cnt=%0d",
               mis_o[0], pc_o[0], cnt_o[0], old_cnt + 1);
    end
  endtask

  task automatic test_stall_jal();
    logic [31:0] cnt0;
    goto_pc(32'h400);
    cnt0 = m_cnt[0];
    stall = 1; pc_select = 3'b010;
    for (int i = 0; i < 4; i++) begin
      // A misaligned immediate early in the stall must not be evaluated.
      immgen_in = (i < 2) ? 32'h42 : 32'h40;
      tick();
      total++;
      if (pc_o[0] !== 32'h400 || cnt_o[0] !== cnt0 || mis_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d: got pc=%h cnt=%0d mis=%b exp pc=400 cnt=%0d mis=0",
                 i, pc_o[0], cnt_o[0], mis_o[0], cnt0);
      end
    end
    stall = 0;
    tick();
    total++;
    if (pc_o[0] !== 32'h440 || cnt_o[0] !== cnt0 + 1) begin
      bad++;
      $display("FAIL stall_release: got pc=%h cnt=%0d exp pc=440 cnt=%0d", pc_o[0], cnt_o[0], cnt0 + 1);
    end
  endtask

  task automatic test_trap_mret();
    goto_pc(32'h300);
    stall = 1; trap_req = 1; trap_vector = 32'h803;
    tick();
    total++;
    if (pc_o[0] !== 32'h800 || epc_o[0] !== 32'h300 || mis_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL trap_in_stall: got pc=%h epc=%h mis=%b exp pc=800 epc=300 mis=0",
               pc_o[0], epc_o[0], mis_o[0]);
    end
    idle_inputs();
    pc_select = 3'b100;
    tick();
    total++;
    if (pc_o[0] !== 32'h300) begin
      bad++;
      $display("FAIL mret: got %h exp 00000300", pc_o[0]);
    end
  endtask

  task automatic test_cnt_wrap();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      total++;
      if (cnt_o[2] !== 32'(i % 16)) begin
        bad++;
        $display("FAIL wrap%0d: got %0d exp %0d", i, cnt_o[2], i % 16);
      end
    end
    total++;
    if (pc_o[2] !== 32'h144) begin
      bad++;
      $display("FAIL wrap_pc: got %h exp 00000144", pc_o[2]);
    end
  endtask

  task automatic test_rst_mid_trap();
    goto_pc(32'h600);
    trap_req = 1; stall = 1; rst = 1; trap_vector = 32'h900;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (pc_o[k] !== RV || epc_o[k] !== 32'h0 || mis_o[k] !== 1'b0 || cnt_o[k] !== 32'h0) begin
        bad++;
        $display("FAIL rst_mid_trap[%0d]: got pc=%h epc=%h mis=%b cnt=%0d exp pc=%h epc=0 mis=0 cnt=0",
                 k, pc_o[k], epc_o[k], mis_o[k], cnt_o[k], RV);
      end
    end
    tick();
    total++;
    if (pc_o[0] !== 32'h104) begin
      bad++;
      $display("FAIL rst_first_seq: got %h exp 00000104", pc_o[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 99) < 2);
      trap_req     = ($urandom_range(0, 99) < 6);
      stall        = ($urandom_range(0, 99) < 20);
      pc_select    = 3'($urandom_range(0, 7));
      branch_taken = 1'($urandom_range(0, 1));
      immgen_in    = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
      alu_in       = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFF9);
      trap_vector  = $urandom;
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (pc_o[k] !== m_pc[k] || epc_o[k] !== m_epc[k] || mis_o[k] !== m_mis[k] ||
            cnt_o[k] !== m_cnt[k] || link_o[k] !== m_pc[k] + 32'd4) begin
          bad++;
          $display("FAIL rand%0d[%0d]: got pc=%h epc=%h mis=%b cnt=%h link=%h exp pc=%h epc=%h mis=%b cnt=%h link=%h",
                   n, k, pc_o[k], epc_o[k], mis_o[k], cnt_o[k], link_o[k],
                   m_pc[k], m_epc[k], m_mis[k], m_cnt[k], m_pc[k] + 32'd4);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_seq();
    test_branch();
    test_jalr_misaligned();
    test_stall_jal();
    test_trap_mret();
    test_cnt_wrap();
    test_rst_mid_trap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the sequence above is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
